// File: rtl/ucpu_pkg.sv
// Shared micro-sequencer definitions: instruction types, sequencer states,
// micro-instruction field offsets and argument bit positions.
package ucpu_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'b000,
    IMM  = 3'b001,
    IMM2 = 3'b010,
    CBR  = 3'b011,
    BR   = 3'b100,
    END  = 3'b111
  } minst_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    ISSUE  = 2'd3
  } seq_state_e;

  // Field layout of a micro-instruction word (fixed positions).
  localparam int TYPE_WIDTH = 3;
  localparam int TYPE_LSB   = 41;
  localparam int SRC_LSB    = 36;
  localparam int DST_LSB    = 31;
  localparam int IMM_LSB    = 20;
  localparam int TGT_LSB    = 10;

  // Bit positions inside args[9:0].
  localparam int ALU_EN = 0;
  localparam int RF_EN  = 4;
  localparam int RF_RW  = 5;
  localparam int MEM_EN = 6;
  localparam int MEM_RW = 7;

  // Types that carry a meaningful immediate.
  function automatic logic is_imm_type(input logic [TYPE_WIDTH-1:0] t);
    return (t == IMM) || (t == IMM2) || (t == CBR);
  endfunction

  // Types that may redirect the micro-PC.
  function automatic logic is_branch_type(input logic [TYPE_WIDTH-1:0] t);
    return (t == CBR) || (t == BR);
  endfunction

endpackage

// File: rtl/minst_field_decode.sv
// Combinational extraction of all control fields from a raw micro-instruction.
// Limits: REG_SPEC_WIDTH <= 5, IMM_WIDTH <= 11, UPC_WIDTH <= 10, ALU_OP_WIDTH <= 3.
module minst_field_decode
  import ucpu_pkg::*;
#(
  parameter int MINST_WIDTH    = 44,
  parameter int REG_SPEC_WIDTH = 5,
  parameter int IMM_WIDTH      = 8,
  parameter int UPC_WIDTH      = 8,
  parameter int ALU_OP_WIDTH   = 3
) (
  input  logic [MINST_WIDTH-1:0]    i_minstr,
  output logic [TYPE_WIDTH-1:0]     o_type,
  output logic [REG_SPEC_WIDTH-1:0] o_src,
  output logic [REG_SPEC_WIDTH-1:0] o_dst,
  output logic [IMM_WIDTH-1:0]      o_imm,
  output logic [UPC_WIDTH-1:0]      o_target,
  output logic                      o_is_imm,
  output logic                      o_is_branch,
  output logic                      o_alu_en,
  output logic [ALU_OP_WIDTH-1:0]   o_alu_op,
  output logic                      o_rf_en,
  output logic                      o_rf_rw,
  output logic                      o_mem_en,
  output logic                      o_mem_rw
);

  // Spare bits of the word are intentionally ignored.
  logic w_unused;

  assign o_type      = i_minstr[TYPE_LSB +: TYPE_WIDTH];
  assign o_src       = i_minstr[SRC_LSB +: REG_SPEC_WIDTH];
  assign o_dst       = i_minstr[DST_LSB +: REG_SPEC_WIDTH];
  assign o_imm       = i_minstr[IMM_LSB +: IMM_WIDTH];
  assign o_target    = i_minstr[TGT_LSB +: UPC_WIDTH];
  assign o_is_imm    = is_imm_type(o_type);
  assign o_is_branch = is_branch_type(o_type);
  assign o_alu_en    = i_minstr[ALU_EN];
  assign o_alu_op    = i_minstr[ALU_EN+1 +: ALU_OP_WIDTH];
  assign o_rf_en     = i_minstr[RF_EN];
  assign o_rf_rw     = i_minstr[RF_RW];
  assign o_mem_en    = i_minstr[MEM_EN];
  assign o_mem_rw    = i_minstr[MEM_RW];
  assign w_unused    = ^i_minstr;

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: owns the micro-PC, fetches from the microcode ROM, registers
// the decoded fields and issues each micro-op over a valid/ready handshake.
// Branches (BR, flag-conditional CBR) are resolved at the issue handshake.
module micro_sequencer
  import ucpu_pkg::*;
#(
  parameter int MINST_WIDTH    = 44,
  parameter int REG_SPEC_WIDTH = 5,
  parameter int IMM_WIDTH      = 8,
  parameter int UPC_WIDTH      = 8,
  parameter int ALU_OP_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [UPC_WIDTH-1:0]      entry_upc_i,
  input  logic                      abort_i,
  input  logic                      flag_i,
  output logic                      rom_en_o,
  output logic [UPC_WIDTH-1:0]      rom_addr_o,
  input  logic [MINST_WIDTH-1:0]    rom_rdata_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [REG_SPEC_WIDTH-1:0] reg_src_o,
  output logic [REG_SPEC_WIDTH-1:0] reg_dst_o,
  output logic [IMM_WIDTH-1:0]      imm_o,
  output logic                      is_imm_active_o,
  output logic                      alu_en_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic                      reg_file_en_o,
  output logic                      reg_file_rw_o,
  output logic                      mem_en_o,
  output logic                      mem_rw_o,
  output logic                      is_branch_o,
  output logic                      busy_o,
  output logic                      done_o
);

  seq_state_e r_state;
  seq_state_e w_state_next;

  logic [UPC_WIDTH-1:0] r_upc;
  logic [UPC_WIDTH-1:0] w_upc_next;
  logic [UPC_WIDTH-1:0] w_upc_inc;
  logic                 w_load_fields;
  logic                 w_done_next;
  logic                 r_done;

  // Combinational decode of the ROM word
  logic [TYPE_WIDTH-1:0]     w_dec_type;
  logic [REG_SPEC_WIDTH-1:0] w_dec_src;
  logic [REG_SPEC_WIDTH-1:0] w_dec_dst;
  logic [IMM_WIDTH-1:0]      w_dec_imm;
  logic [UPC_WIDTH-1:0]      w_dec_target;
  logic                      w_dec_is_imm;
  logic                      w_dec_is_branch;
  logic                      w_dec_alu_en;
  logic [ALU_OP_WIDTH-1:0]   w_dec_alu_op;
  logic                      w_dec_rf_en;
  logic                      w_dec_rf_rw;
  logic                      w_dec_mem_en;
  logic                      w_dec_mem_rw;

  // Registered decoded fields, captured in DECODE
  logic [TYPE_WIDTH-1:0]     r_type;
  logic [REG_SPEC_WIDTH-1:0] r_src;
  logic [REG_SPEC_WIDTH-1:0] r_dst;
  logic [IMM_WIDTH-1:0]      r_imm;
  logic [UPC_WIDTH-1:0]      r_target;
  logic                      r_is_imm;
  logic                      r_is_branch;
  logic                      r_alu_en;
  logic [ALU_OP_WIDTH-1:0]   r_alu_op;
  logic                      r_rf_en;
  logic                      r_rf_rw;
  logic                      r_mem_en;
  logic                      r_mem_rw;

  minst_field_decode #(
    .MINST_WIDTH    (MINST_WIDTH),
    .REG_SPEC_WIDTH (REG_SPEC_WIDTH),
    .IMM_WIDTH      (IMM_WIDTH),
    .UPC_WIDTH      (UPC_WIDTH),
    .ALU_OP_WIDTH   (ALU_OP_WIDTH)
  ) u_decode (
    .i_minstr    (rom_rdata_i),
    .o_type      (w_dec_type),
    .o_src       (w_dec_src),
    .o_dst       (w_dec_dst),
    .o_imm       (w_dec_imm),
    .o_target    (w_dec_target),
    .o_is_imm    (w_dec_is_imm),
    .o_is_branch (w_dec_is_branch),
    .o_alu_en    (w_dec_alu_en),
    .o_alu_op    (w_dec_alu_op),
    .o_rf_en     (w_dec_rf_en),
    .o_rf_rw     (w_dec_rf_rw),
    .o_mem_en    (w_dec_mem_en),
    .o_mem_rw    (w_dec_mem_rw)
  );

  // Sequential increment wraps naturally at the uPC width.
  assign w_upc_inc = r_upc + UPC_WIDTH'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, next uPC, field capture and done decisions; abort wins over everything
  always_comb begin
    w_state_next  = r_state;
    w_upc_next    = r_upc;
    w_load_fields = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !abort_i) begin
          w_upc_next   = entry_upc_i;
          w_state_next = FETCH;
        end else begin
          w_state_next = IDLE;
        end
      end
      FETCH: begin
        if (abort_i) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        if (abort_i) begin
          w_state_next = IDLE;
        end else begin
          w_load_fields = 1'b1;
          w_state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          w_state_next = IDLE;
        end else if (out_ready_i) begin
          case (r_type)
            BR: begin
              w_upc_next   = r_target;
              w_state_next = FETCH;
            end
            CBR: begin
              w_upc_next   = flag_i ? r_target : w_upc_inc;
              w_state_next = FETCH;
            end
            END: begin
              w_done_next  = 1'b1;
              w_state_next = IDLE;
            end
            default: begin
              w_upc_next   = w_upc_inc;
              w_state_next = FETCH;
            end
          endcase
        end else begin
          w_state_next = ISSUE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // uPC, done pulse and decoded field registers; fields hold outside DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upc       <= '0;
      r_done      <= 1'b0;
      r_type      <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_imm       <= '0;
      r_target    <= '0;
      r_is_imm    <= 1'b0;
      r_is_branch <= 1'b0;
      r_alu_en    <= 1'b0;
      r_alu_op    <= '0;
      r_rf_en     <= 1'b0;
      r_rf_rw     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
    end else begin
      r_upc  <= w_upc_next;
      r_done <= w_done_next;
      if (w_load_fields) begin
        r_type      <= w_dec_type;
        r_src       <= w_dec_src;
        r_dst       <= w_dec_dst;
        r_imm       <= w_dec_imm;
        r_target    <= w_dec_target;
        r_is_imm    <= w_dec_is_imm;
        r_is_branch <= w_dec_is_branch;
        r_alu_en    <= w_dec_alu_en;
        r_alu_op    <= w_dec_alu_op;
        r_rf_en     <= w_dec_rf_en;
        r_rf_rw     <= w_dec_rf_rw;
        r_mem_en    <= w_dec_mem_en;
        r_mem_rw    <= w_dec_mem_rw;
      end
    end
  end

  assign rom_en_o        = (r_state == FETCH);
  assign rom_addr_o      = r_upc;
  assign out_valid_o     = (r_state == ISSUE);
  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
  assign reg_src_o       = r_src;
  assign reg_dst_o       = r_dst;
  assign imm_o           = r_imm;
  assign is_imm_active_o = r_is_imm;
  assign is_branch_o     = r_is_branch;
  assign alu_en_o        = r_alu_en;
  assign alu_op_o        = r_alu_op;
  assign reg_file_en_o   = r_rf_en;
  assign reg_file_rw_o   = r_rf_rw;
  assign mem_en_o        = r_mem_en;
  assign mem_rw_o        = r_mem_rw;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: programs are laid into a ROM model,
// a reference walk queues the expected micro-ops, a monitor checks them.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  entry_upc_i;
  logic        abort_i;
  logic        flag_i;
  logic        rom_en_o;
  logic [7:0]  rom_addr_o;
  logic [43:0] rom_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  reg_src_o, reg_dst_o;
  logic [7:0]  imm_o;
  logic        is_imm_active_o, alu_en_o;
  logic [2:0]  alu_op_o;
  logic        reg_file_en_o, reg_file_rw_o, mem_en_o, mem_rw_o;
  logic        is_branch_o, busy_o, done_o;

  micro_sequencer #(
    .MINST_WIDTH(44), .REG_SPEC_WIDTH(5), .IMM_WIDTH(8), .UPC_WIDTH(8), .ALU_OP_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .entry_upc_i(entry_upc_i),
    .abort_i(abort_i), .flag_i(flag_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_rdata_i(rom_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .reg_src_o(reg_src_o), .reg_dst_o(reg_dst_o), .imm_o(imm_o),
    .is_imm_active_o(is_imm_active_o), .alu_en_o(alu_en_o), .alu_op_o(alu_op_o),
    .reg_file_en_o(reg_file_en_o), .reg_file_rw_o(reg_file_rw_o),
    .mem_en_o(mem_en_o), .mem_rw_o(mem_rw_o), .is_branch_o(is_branch_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [4:0] src, dst;
    logic [7:0] imm;
    logic       is_imm, alu_en;
    logic [2:0] alu_op;
    logic       rf_en, rf_rw, mem_en, mem_rw, is_branch, is_end;
  } exp_t;

  exp_t        exp_q[$];
  logic [43:0] prog_q[$];
  logic [43:0] rom [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_mode = 0;   // 0: random ready each cycle, 1: driven by the test thread
  bit          mon_en = 1'b0;
  bit          done_pend = 1'b0;

  logic [27:0] act_fields;
  logic [39:0] all_outs;
  assign act_fields = {reg_src_o, reg_dst_o, imm_o, is_imm_active_o, alu_en_o, alu_op_o,
                       reg_file_en_o, reg_file_rw_o, mem_en_o, mem_rw_o, is_branch_o};
  assign all_outs   = {rom_en_o, rom_addr_o, out_valid_o, act_fields, busy_o, done_o};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: what one ROM word at address u must present on issue.
  function automatic exp_t model_op(input logic [7:0] u, input logic [43:0] w);
    exp_t e;
    logic [2:0] t;
    t           = w[43:41];
    e.addr      = u;
    e.src       = w[40:36];
    e.dst       = w[35:31];
    e.imm       = w[27:20];
    e.is_imm    = (t == 3'd1) || (t == 3'd2) || (t == 3'd3);
    e.alu_en    = w[0];
    e.alu_op    = w[3:1];
    e.rf_en     = w[4];
    e.rf_rw     = w[5];
    e.mem_en    = w[6];
    e.mem_rw    = w[7];
    e.is_branch = (t == 3'd3) || (t == 3'd4);
    e.is_end    = (t == 3'd7);
    return e;
  endfunction

  function automatic logic [7:0] next_upc(input logic [7:0] u, input logic [43:0] w, input logic f);
    int seq;
    seq = (int'(u) + 1) % 256;
    case (w[43:41])
      3'd4:    return w[17:10];
      3'd3:    return f ? w[17:10] : 8'(seq);
      default: return 8'(seq);
    endcase
  endfunction

  function automatic logic [27:0] pack_exp(input exp_t e);
    return {e.src, e.dst, e.imm, e.is_imm, e.alu_en, e.alu_op,
            e.rf_en, e.rf_rw, e.mem_en, e.mem_rw, e.is_branch};
  endfunction

  function automatic logic [43:0] mk_word(input logic [2:0] t, input logic [4:0] s, input logic [4:0] d,
                                          input logic [7:0] imm, input logic [7:0] tgt, input logic [9:0] args);
    logic [43:0] w;
    w = 44'h0;
    w[43:41] = t; w[40:36] = s; w[35:31] = d; w[27:20] = imm; w[17:10] = tgt; w[9:0] = args;
    return w;
  endfunction

  function automatic logic [43:0] rand_word(input logic [2:0] t);
    logic [63:0] r;
    logic [43:0] w;
    r = {$urandom(), $urandom()};
    w = r[43:0];
    w[43:41] = t;
    return w;
  endfunction

  // Write prog_q into ROM along the reference walk and queue the expectations.
  task automatic load_program(input logic [7:0] entry, input logic flag);
    logic [7:0] u;
    u = entry;
    foreach (prog_q[i]) begin
      rom[u] = prog_q[i];
      exp_q.push_back(model_op(u, prog_q[i]));
      u = next_upc(u, prog_q[i], flag);
    end
    flag_i = flag;
  endtask

  // Random program that never revisits an address and always ends with END.
  task automatic gen_random(output logic [7:0] entry, output logic flag);
    bit visited [256];
    int n;
    logic [7:0] u, nu;
    logic [43:0] w;
    bit ok;
    for (int i = 0; i < 256; i++) visited[i] = 1'b0;
    n     = $urandom_range(1, 10);
    entry = 8'($urandom());
    flag  = 1'($urandom());
    u     = entry;
    prog_q.delete();
    for (int k = 0; k < n - 1; k++) begin
      visited[u] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 8 && !ok; t++) begin
        w  = rand_word(3'($urandom_range(0, 6)));
        nu = next_upc(u, w, flag);
        ok = !visited[nu];
      end
      if (!ok) break;
      prog_q.push_back(w);
      u = nu;
    end
    prog_q.push_back(rand_word(3'd7));
  endtask

  task automatic pulse_start(input logic [7:0] e);
    start_i     = 1'b1;
    entry_upc_i = e;
    @(posedge clk); #1;
    start_i     = 1'b0;
    entry_upc_i = 8'($urandom());
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!out_valid_o && k < budget) begin @(posedge clk); #1; k++; end
    if (!out_valid_o) fail_now("wait_valid_timeout");
  endtask

  task automatic run_to_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < budget) begin @(posedge clk); #1; k++; end
    if (exp_q.size() != 0 || busy_o) begin
      fail_now("sequence_timeout");
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      exp_q.delete();
    end
  endtask

  // ROM model: data for an address strobed in one cycle appears in the next
  initial begin
    logic en;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      en = rom_en_o;
      a  = rom_addr_o;
      @(posedge clk); #1;
      rom_rdata_i = en ? rom[a] : rand_word(3'($urandom()));
    end
  end

  // Random backpressure when the test thread is not steering ready
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: fetch address, issued fields, handshakes and done pulse
  always @(negedge clk) begin
    if (mon_en) begin
      check("done_o", done_o, done_pend);
      done_pend = 1'b0;
      if (rom_en_o) begin
        if (exp_q.size() == 0) fail_now("unexpected_fetch");
        else check("rom_addr", rom_addr_o, exp_q[0].addr);
      end
      if (out_valid_o) begin
        if (exp_q.size() == 0) fail_now("unexpected_valid");
        else begin
          check("fields", act_fields, pack_exp(exp_q[0]));
          if (out_ready_i && !abort_i) begin
            done_pend = exp_q[0].is_end;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    logic f;
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; flag_i = 1'b0;
    out_ready_i = 1'b0; entry_upc_i = 8'h00; rom_rdata_i = 44'h0;
    for (int i = 0; i < 256; i++) rom[i] = 44'h0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs, 40'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_outputs", all_outs, 40'h0);
    mon_en = 1'b1;

    // Directed: IMM at 0x10 then END, latency and stall behaviour
    prog_q.delete();
    prog_q.push_back(mk_word(3'd1, 5'd0, 5'd3, 8'h5A, 8'h00, 10'h013));
    prog_q.push_back(mk_word(3'd7, 5'd1, 5'd2, 8'h00, 8'h00, 10'h000));
    load_program(8'h10, 1'b0);
    pulse_start(8'h10);
    check("c1_rom_en", rom_en_o, 1'b1);
    check("c1_rom_addr", rom_addr_o, 8'h10);
    @(posedge clk); #1;
    check("c2_valid", out_valid_o, 1'b0);
    @(posedge clk); #1;
    check("c3_valid", out_valid_o, 1'b1);
    check("c3_dst", reg_dst_o, 5'd3);
    check("c3_imm", imm_o, 8'h5A);
    check("c3_is_imm", is_imm_active_o, 1'b1);
    check("c3_alu", {alu_en_o, alu_op_o, reg_file_en_o}, 5'b1_001_1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid_o, 1'b1);
      check("stall_no_fetch", rom_en_o, 1'b0);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check("advance_fetch", rom_en_o, 1'b1);
    check("advance_addr", rom_addr_o, 8'h11);
    ready_mode = 0;
    run_to_idle(200);

    // Directed: conditional branch at 0x20, taken and not taken; wrap at 0xFF
    for (int k = 0; k < 3; k++) begin
      prog_q.delete();
      if (k < 2) prog_q.push_back(mk_word(3'd3, 5'd4, 5'd5, 8'hC3, 8'h40, 10'h0F0));
      else prog_q.push_back(mk_word(3'd0, 5'd7, 5'd9, 8'h11, 8'h22, 10'h2AA));
      prog_q.push_back(mk_word(3'd7, 5'd0, 5'd0, 8'h00, 8'h00, 10'h000));
      e = (k < 2) ? 8'h20 : 8'hFF;
      load_program(e, (k == 0));
      pulse_start(e);
      run_to_idle(200);
      check("seq_end_busy", busy_o, 1'b0);
    end

    // Directed: abort together with ready in ISSUE
    ready_mode = 1;
    out_ready_i = 1'b0;
    prog_q.delete();
    prog_q.push_back(mk_word(3'd2, 5'd1, 5'd1, 8'h77, 8'h00, 10'h0C1));
    prog_q.push_back(mk_word(3'd7, 5'd0, 5'd0, 8'h00, 8'h00, 10'h000));
    load_program(8'h30, 1'b0);
    pulse_start(8'h30);
    wait_valid(20);
    abort_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    out_ready_i = 1'b0;
    exp_q.delete();
    check("abort_busy", busy_o, 1'b0);
    check("abort_valid", out_valid_o, 1'b0);
    check("abort_upc", rom_addr_o, 8'h30);

    // Directed: start together with abort in IDLE is ignored
    start_i = 1'b1; abort_i = 1'b1; entry_upc_i = 8'h55;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("start_abort_busy", busy_o, 1'b0);
    check("start_abort_upc", rom_addr_o, 8'h30);
    @(posedge clk); #1;
    check("start_abort_no_fetch", rom_en_o, 1'b0);

    // Randomized programs with random backpressure
    ready_mode = 0;
    for (int s = 0; s < 40; s++) begin
      gen_random(e, f);
      load_program(e, f);
      pulse_start(e);
      run_to_idle(400);
    end

    // Directed: reset while a micro-op waits in ISSUE
    ready_mode = 1;
    out_ready_i = 1'b0;
    prog_q.delete();
    prog_q.push_back(mk_word(3'd4, 5'd3, 5'd6, 8'hE1, 8'h90, 10'h3FF));
    prog_q.push_back(mk_word(3'd7, 5'd0, 5'd0, 8'h00, 8'h00, 10'h000));
    load_program(8'hA5, 1'b1);
    pulse_start(8'hA5);
    wait_valid(20);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("reset_mid_outputs", all_outs, 40'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("after_reset_no_fetch", {rom_en_o, busy_o}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
